// File: rtl/p4_wrapper_pkg.sv
// Shared defaults and helpers for the P4 wrapper blocks.
// Holds parameter defaults and a constant clog2.
package p4_wrapper_pkg;

  localparam int TUSER_WIDTH_DEF = 128;
  localparam int DEPTH_DEF       = 16;
  localparam int CNT_WIDTH_DEF   = 32;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/meta_fifo.sv
// First-word-fall-through metadata FIFO.
// Caller qualifies push/pop; head shows combinationally.
module meta_fifo
  import p4_wrapper_pkg::*;
#(
  parameter int W     = TUSER_WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        push_i,
  input  logic                        pop_i,
  input  logic [W-1:0]                wdata_i,
  output logic [W-1:0]                rdata_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [clog2(DEPTH+1)-1:0]   level_o
);

  localparam int PW = clog2(DEPTH);
  localparam int LW = clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q;
  logic [PW-1:0] rptr_q;
  logic [LW-1:0] level_q;
  logic [LW-1:0] level_d;

  // Occupancy follows the net of accepted push and pop
  always_comb begin
    level_d = level_q;
    unique case ({push_i, pop_i})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Storage is plain RAM, deliberately left out of reset
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  // Pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + PW'(1);
      if (pop_i)  rptr_q <= rptr_q + PW'(1);
      level_q <= level_d;
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

endmodule

// File: rtl/tuser_pkt_align.sv
// Aligns per-packet TUSER from the input side to the output side.
// Tracks SOP on both taps, drives holds, counters and error flags.
module tuser_pkt_align
  import p4_wrapper_pkg::*;
#(
  parameter int TUSER_WIDTH   = TUSER_WIDTH_DEF,
  parameter int DEPTH         = DEPTH_DEF,
  parameter int CNT_WIDTH     = CNT_WIDTH_DEF,
  parameter int HOLD_ON_EMPTY = 1
) (
  input  logic                      axis_aclk,
  input  logic                      axis_rst,
  input  logic                      in_tvalid,
  input  logic                      in_tready,
  input  logic                      in_tlast,
  input  logic [TUSER_WIDTH-1:0]    in_tuser,
  output logic                      in_hold,
  input  logic                      out_tvalid,
  input  logic                      out_tready,
  input  logic                      out_tlast,
  output logic [TUSER_WIDTH-1:0]    out_tuser,
  output logic                      out_hold,
  output logic [clog2(DEPTH+1)-1:0] level,
  output logic [CNT_WIDTH-1:0]      pkt_in_cnt,
  output logic [CNT_WIDTH-1:0]      pkt_out_cnt,
  output logic                      err_overflow,
  output logic                      err_underflow
);

  logic                   in_sop_q;
  logic                   out_sop_q;
  logic                   skip_q;
  logic [CNT_WIDTH-1:0]   in_cnt_q;
  logic [CNT_WIDTH-1:0]   out_cnt_q;
  logic                   ovf_q;
  logic                   udf_q;

  logic                   in_hs;
  logic                   out_hs;
  logic                   push_req;
  logic                   push;
  logic                   pop;
  logic                   ovf_ev;
  logic                   udf_ev;
  logic                   cur_skip;
  logic                   full;
  logic                   empty;
  logic [TUSER_WIDTH-1:0] head;

  assign in_hs    = in_tvalid & in_tready;
  assign out_hs   = out_tvalid & out_tready;
  assign push_req = in_hs & in_sop_q;
  // A pop in the same cycle frees the slot, so full is not an overflow then
  assign push     = push_req & (~full | pop);
  assign ovf_ev   = push_req & full & ~pop;
  // A packet that started on an empty FIFO owns no entry
  assign cur_skip = out_sop_q ? empty : skip_q;
  assign pop      = out_hs & out_tlast & ~empty & ~cur_skip;
  assign udf_ev   = out_hs & out_sop_q & empty;

  meta_fifo #(
    .W     (TUSER_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (axis_aclk),
    .rst_i   (axis_rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (in_tuser),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  // SOP tracking, skip marker, counters and sticky error flags
  always_ff @(posedge axis_aclk or posedge axis_rst) begin
    if (axis_rst) begin
      in_sop_q  <= 1'b1;
      out_sop_q <= 1'b1;
      skip_q    <= 1'b0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      if (in_hs)  in_sop_q  <= in_tlast;
      if (out_hs) out_sop_q <= out_tlast;
      if (out_hs && out_sop_q) skip_q <= empty;
      if (push)   in_cnt_q  <= in_cnt_q + CNT_WIDTH'(1);
      if (pop)    out_cnt_q <= out_cnt_q + CNT_WIDTH'(1);
      if (ovf_ev) ovf_q     <= 1'b1;
      if (udf_ev) udf_q     <= 1'b1;
    end
  end

  assign in_hold       = full & in_sop_q;
  assign out_hold      = (HOLD_ON_EMPTY != 0) & empty & out_sop_q;
  assign out_tuser     = empty ? '0 : head;
  assign pkt_in_cnt    = in_cnt_q;
  assign pkt_out_cnt   = out_cnt_q;
  assign err_overflow  = ovf_q;
  assign err_underflow = udf_q;

endmodule

// File: tb/tb_tuser_pkt_align.sv
// Directed bench for tuser_pkt_align: vector table plus corner sequences.
// Instance A: DEPTH=4 hold-on-empty; instance B: pass-through, 2-bit counters.
module tb_tuser_pkt_align;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       a_iv, a_ir, a_il, a_ov, a_or, a_ol;
  logic [7:0] a_iu, a_ou;
  logic       a_ih, a_oh, a_ovf, a_udf;
  logic [2:0] a_lvl;
  logic [7:0] a_icnt, a_ocnt;

  logic       b_iv, b_ir, b_il, b_ov, b_or, b_ol;
  logic [7:0] b_iu, b_ou;
  logic       b_ih, b_oh, b_ovf, b_udf;
  logic [2:0] b_lvl;
  logic [1:0] b_icnt, b_ocnt;

  tuser_pkt_align #(
    .TUSER_WIDTH(8), .DEPTH(4), .CNT_WIDTH(8), .HOLD_ON_EMPTY(1)
  ) u_a (
    .axis_aclk(clk), .axis_rst(rst),
    .in_tvalid(a_iv), .in_tready(a_ir), .in_tlast(a_il),
    .in_tuser(a_iu), .in_hold(a_ih),
    .out_tvalid(a_ov), .out_tready(a_or), .out_tlast(a_ol),
    .out_tuser(a_ou), .out_hold(a_oh), .level(a_lvl),
    .pkt_in_cnt(a_icnt), .pkt_out_cnt(a_ocnt),
    .err_overflow(a_ovf), .err_underflow(a_udf)
  );

  tuser_pkt_align #(
    .TUSER_WIDTH(8), .DEPTH(4), .CNT_WIDTH(2), .HOLD_ON_EMPTY(0)
  ) u_b (
    .axis_aclk(clk), .axis_rst(rst),
    .in_tvalid(b_iv), .in_tready(b_ir), .in_tlast(b_il),
    .in_tuser(b_iu), .in_hold(b_ih),
    .out_tvalid(b_ov), .out_tready(b_or), .out_tlast(b_ol),
    .out_tuser(b_ou), .out_hold(b_oh), .level(b_lvl),
    .pkt_in_cnt(b_icnt), .pkt_out_cnt(b_ocnt),
    .err_overflow(b_ovf), .err_underflow(b_udf)
  );

  typedef struct {
    bit iv, ir, il;
    logic [7:0] iu;
    bit ov, orr, ol;
    logic [7:0] eu;
    logic [2:0] el;
    bit eih, eoh;
  } vec_t;

  vec_t tv[$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic vec_t mk(
    bit iv, bit ir, bit il, logic [7:0] iu,
    bit ov, bit orr, bit ol,
    logic [7:0] eu, int el, bit eih, bit eoh);
    vec_t v;
    v.iv = iv; v.ir = ir; v.il = il; v.iu = iu;
    v.ov = ov; v.orr = orr; v.ol = ol;
    v.eu = eu; v.el = 3'(el); v.eih = eih; v.eoh = eoh;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drv_a(input bit iv, input bit ir, input bit il,
                       input logic [7:0] iu,
                       input bit ov, input bit orr, input bit ol);
    @(posedge clk); #1;
    a_iv = iv; a_ir = ir; a_il = il; a_iu = iu;
    a_ov = ov; a_or = orr; a_ol = ol;
  endtask

  task automatic drv_b(input bit iv, input bit ir, input bit il,
                       input logic [7:0] iu,
                       input bit ov, input bit orr, input bit ol);
    @(posedge clk); #1;
    b_iv = iv; b_ir = ir; b_il = il; b_iu = iu;
    b_ov = ov; b_or = orr; b_ol = ol;
  endtask

  initial begin
    {a_iv, a_ir, a_il, a_ov, a_or, a_ol} = '0;
    {b_iv, b_ir, b_il, b_ov, b_or, b_ol} = '0;
    a_iu = '0;
    b_iu = '0;

    // iv ir il iu | ov or ol | tuser level in_hold out_hold
    tv.push_back(mk(1,1,1,8'hA1, 0,0,0, 8'h00,0,0,1));
    tv.push_back(mk(1,1,1,8'hA2, 0,0,0, 8'hA1,1,0,0));
    tv.push_back(mk(1,1,1,8'hA3, 1,1,1, 8'hA1,2,0,0));
    tv.push_back(mk(0,0,0,8'h00, 1,1,1, 8'hA2,2,0,0));
    tv.push_back(mk(0,0,0,8'h00, 1,1,1, 8'hA3,1,0,0));
    tv.push_back(mk(0,0,0,8'h00, 0,0,0, 8'h00,0,0,1));
    tv.push_back(mk(1,1,1,8'hB1, 1,0,1, 8'h00,0,0,1));
    tv.push_back(mk(1,1,1,8'hB2, 1,0,1, 8'hB1,1,0,0));
    tv.push_back(mk(1,1,1,8'hB3, 1,0,1, 8'hB1,2,0,0));
    tv.push_back(mk(1,1,0,8'hB4, 1,0,1, 8'hB1,3,0,0));
    tv.push_back(mk(1,1,1,8'hEE, 1,0,1, 8'hB1,4,0,0));
    tv.push_back(mk(1,0,1,8'hB5, 1,0,1, 8'hB1,4,1,0));
    tv.push_back(mk(1,0,1,8'hB5, 1,1,1, 8'hB1,4,1,0));
    tv.push_back(mk(1,0,1,8'hB5, 1,0,1, 8'hB2,3,0,0));
    tv.push_back(mk(1,1,1,8'hB5, 0,0,0, 8'hB2,3,0,0));
    tv.push_back(mk(0,0,0,8'h00, 0,0,0, 8'hB2,4,1,0));
    tv.push_back(mk(1,1,1,8'hB6, 1,1,1, 8'hB2,4,1,0));
    tv.push_back(mk(0,0,0,8'h00, 0,0,0, 8'hB3,4,1,0));
    tv.push_back(mk(0,0,0,8'h00, 1,0,0, 8'hB3,4,1,0));
    tv.push_back(mk(0,0,0,8'h00, 1,1,0, 8'hB3,4,1,0));
    tv.push_back(mk(0,0,0,8'h00, 1,0,0, 8'hB3,4,1,0));
    tv.push_back(mk(0,0,0,8'h00, 1,1,0, 8'hB3,4,1,0));
    tv.push_back(mk(0,0,0,8'h00, 1,0,0, 8'hB3,4,1,0));
    tv.push_back(mk(0,0,0,8'h00, 1,1,0, 8'hB3,4,1,0));
    tv.push_back(mk(0,0,0,8'h00, 1,0,1, 8'hB3,4,1,0));
    tv.push_back(mk(0,0,0,8'h00, 1,1,1, 8'hB3,4,1,0));
    tv.push_back(mk(0,0,0,8'h00, 0,0,0, 8'hB4,3,0,0));
    tv.push_back(mk(0,0,0,8'h00, 1,1,1, 8'hB4,3,0,0));
    tv.push_back(mk(0,0,0,8'h00, 1,1,1, 8'hB5,2,0,0));
    tv.push_back(mk(0,0,0,8'h00, 1,1,1, 8'hB6,1,0,0));
    tv.push_back(mk(0,0,0,8'h00, 0,0,0, 8'h00,0,0,1));

    #2 rst = 1'b1;
    #1;
    chk("rst_a_level", a_lvl, 0);
    chk("rst_a_in_hold", a_ih, 0);
    chk("rst_a_out_hold", a_oh, 1);
    chk("rst_a_tuser", a_ou, 0);
    chk("rst_a_cnt", {a_icnt, a_ocnt}, 0);
    chk("rst_a_err", {a_ovf, a_udf}, 0);
    chk("rst_b_out_hold", b_oh, 0);
    #9 rst = 1'b0;

    foreach (tv[i]) begin
      drv_a(tv[i].iv, tv[i].ir, tv[i].il, tv[i].iu,
            tv[i].ov, tv[i].orr, tv[i].ol);
      @(negedge clk);
      chk($sformatf("v%0d tuser", i), a_ou, tv[i].eu);
      chk($sformatf("v%0d level", i), a_lvl, tv[i].el);
      chk($sformatf("v%0d in_hold", i), a_ih, tv[i].eih);
      chk($sformatf("v%0d out_hold", i), a_oh, tv[i].eoh);
    end
    chk("tbl_in_cnt", a_icnt, 9);
    chk("tbl_out_cnt", a_ocnt, 9);
    chk("tbl_ovf", a_ovf, 0);

    // Overflow: fill, then push once more with no pop
    for (int i = 0; i < 4; i++)
      drv_a(1, 1, 1, 8'hC1 + 8'(i), 0, 0, 0);
    drv_a(1, 1, 1, 8'hC5, 0, 0, 0);
    @(negedge clk);
    chk("ovf_pre_flag", a_ovf, 0);
    chk("ovf_pre_hold", a_ih, 1);
    drv_a(0, 0, 0, 8'h00, 0, 0, 0);
    @(negedge clk);
    chk("ovf_flag", a_ovf, 1);
    chk("ovf_level", a_lvl, 4);
    chk("ovf_in_cnt", a_icnt, 13);
    chk("ovf_head", a_ou, 8'hC1);

    // Build level=3 with both sides mid-packet, then reset
    drv_a(0, 0, 0, 8'h00, 1, 1, 1);
    drv_a(0, 0, 0, 8'h00, 1, 1, 1);
    drv_a(1, 1, 0, 8'hD1, 1, 1, 0);
    drv_a(0, 0, 0, 8'h00, 0, 0, 0);
    @(negedge clk);
    chk("mid_level", a_lvl, 3);
    chk("mid_head", a_ou, 8'hC3);
    chk("mid_cnts", {a_icnt, a_ocnt}, {8'd14, 8'd11});
    #1 rst = 1'b1;
    #1;
    chk("arst_level", a_lvl, 0);
    chk("arst_cnts", {a_icnt, a_ocnt}, 0);
    chk("arst_errs", {a_ovf, a_udf}, 0);
    chk("arst_in_hold", a_ih, 0);
    chk("arst_out_hold", a_oh, 1);
    chk("arst_tuser", a_ou, 0);
    #1 rst = 1'b0;
    drv_a(1, 1, 1, 8'hE1, 0, 0, 0);
    @(negedge clk);
    chk("post_pre_level", a_lvl, 0);
    drv_a(0, 0, 0, 8'h00, 1, 1, 1);
    @(negedge clk);
    chk("post_tuser", a_ou, 8'hE1);
    chk("post_in_cnt", a_icnt, 1);
    drv_a(0, 0, 0, 8'h00, 0, 0, 0);
    @(negedge clk);
    chk("post_out_cnt", a_ocnt, 1);
    chk("post_level", a_lvl, 0);

    // Pass-through instance: underflow packet, then counter wrap
    drv_b(0, 0, 0, 8'h00, 1, 1, 0);
    @(negedge clk);
    chk("b_udf_tuser", b_ou, 0);
    chk("b_udf_hold", b_oh, 0);
    drv_b(1, 1, 1, 8'hF1, 1, 1, 1);
    @(negedge clk);
    chk("b_udf_flag", b_udf, 1);
    drv_b(0, 0, 0, 8'h00, 0, 0, 0);
    @(negedge clk);
    chk("b_udf_ocnt", b_ocnt, 0);
    chk("b_udf_level", b_lvl, 1);
    chk("b_head", b_ou, 8'hF1);
    drv_b(0, 0, 0, 8'h00, 1, 1, 1);
    drv_b(0, 0, 0, 8'h00, 0, 0, 0);
    @(negedge clk);
    chk("b_pop_ocnt", b_ocnt, 1);
    for (int i = 0; i < 4; i++)
      drv_b(1, 1, 1, 8'h10 + 8'(i), 0, 0, 0);
    drv_b(0, 0, 0, 8'h00, 0, 0, 0);
    @(negedge clk);
    chk("b_wrap_icnt", b_icnt, 1);
    chk("b_full_level", b_lvl, 4);
    for (int i = 0; i < 4; i++)
      drv_b(0, 0, 0, 8'h00, 1, 1, 1);
    drv_b(0, 0, 0, 8'h00, 0, 0, 0);
    @(negedge clk);
    chk("b_wrap_ocnt", b_ocnt, 1);
    chk("b_end_level", b_lvl, 0);
    chk("b_end_errs", {b_ovf, b_udf}, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
